uart_prog_loader: RTL and testbench

Receives a program image over the board UART RX line, assembles 16-bit instruction words and writes them sequentially into the instruction BSRAM from address 0. It sits directly upstream of the BSRAM write port and replaces the fixed boot table. It drives the memory write address, data and write-enable, and holds the CPU in boot mode until a frame with a valid checksum has been loaded.

---
 rtl/loader_pkg.sv | 16 +
 rtl/uart_rx_byte.sv | 101 ++++++++++
 rtl/uart_prog_loader.sv | 128 ++++++++++++
 tb/tb_uart_prog_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types for the UART program loader.
// Parser states and the frame sync byte.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    HI,
    LO,
    WRITE,
    CSUM
  } ldr_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with 2-FF synchronizer.
// Pulses valid or frame_err at the stop-bit centre.
module uart_rx_byte #(
  parameter int CLK_HZ = 27_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  rx_state_t   st;
  logic        s1, s2, s3;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  // Synchronize the line; s3 is the previous sample for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= uart_rx;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Bit timing and deserialization.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      unique case (st)
        RX_IDLE: begin
          cnt <= '0;
          if (s3 && !s2) st <= RX_START;
        end
        RX_START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            st      <= s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == CW'(CPB - 1)) begin
            cnt   <= '0;
            shreg <= {s2, shreg[7:1]};
            if (bit_idx == 3'd7) st <= RX_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == CW'(CPB - 1)) begin
            cnt <= '0;
            st  <= RX_IDLE;
            if (s2) begin
              valid <= 1'b1;
              data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Loads a checksummed program image from UART into BSRAM.
// Holds boot_mode until a good frame has been accepted.
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int CLK_HZ      = 27_000_000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 11,
  parameter int TIMEOUT_CYC = 2_700_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              mem_we,
  output logic              boot_mode,
  output logic              done,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  ldr_state_t  state;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ferr;
  logic [7:0]  n_words;
  logic [8:0]  wcnt;
  logic [7:0]  hi_byte;
  logic [7:0]  acc;
  logic [TW-1:0] to_cnt;
  logic        waiting;
  logic        to_hit;

  uart_rx_byte #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .data     (rx_data),
    .valid    (rx_valid),
    .frame_err(rx_ferr)
  );

  assign waiting = (state == LEN) || (state == HI) ||
                   (state == LO) || (state == CSUM);
  assign to_hit  = waiting && !rx_valid &&
                   (to_cnt >= TW'(TIMEOUT_CYC - 1));

  // Saturating idle-gap counter, cleared by each byte.
  always_ff @(posedge clk) begin
    if (rst || rx_valid || !waiting) to_cnt <= '0;
    else if (to_cnt != TW'(TIMEOUT_CYC)) to_cnt <= to_cnt + 1'b1;
  end

  // Frame parser with registered memory and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_we    <= 1'b0;
      boot_mode <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      n_words   <= '0;
      wcnt      <= '0;
      hi_byte   <= '0;
      acc       <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      if (rx_ferr) begin
        err   <= 1'b1;
        state <= IDLE;
      end else if (to_hit) begin
        err   <= 1'b1;
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: if (rx_valid && rx_data == SYNC_BYTE) begin
            state     <= LEN;
            boot_mode <= 1'b1;
            err       <= 1'b0;
            mem_addr  <= '0;
            acc       <= '0;
            wcnt      <= '0;
          end
          LEN: if (rx_valid) begin
            n_words <= rx_data;
            state   <= (rx_data != 8'd0) ? HI : CSUM;
          end
          HI: if (rx_valid) begin
            hi_byte <= rx_data;
            acc     <= acc ^ rx_data;
            state   <= LO;
          end
          LO: if (rx_valid) begin
            mem_din <= {hi_byte, rx_data};
            acc     <= acc ^ rx_data;
            mem_we  <= 1'b1;
            state   <= WRITE;
          end
          WRITE: begin
            mem_addr <= mem_addr + 1'b1;
            wcnt     <= wcnt + 9'd1;
            if (wcnt + 9'd1 == {1'b0, n_words}) state <= CSUM;
            else state <= HI;
          end
          CSUM: if (rx_valid) begin
            if (rx_data == acc) begin
              done      <= 1'b1;
              boot_mode <= 1'b0;
            end else begin
              err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scenario bench for uart_prog_loader.
// Scoreboard of expected BSRAM writes vs observed.
module tb_uart_prog_loader;
  import loader_pkg::*;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 62_500;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int TO     = 2000;
  localparam int AW     = 11;

  typedef logic [AW+15:0] wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          uart_rx = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic          mem_we;
  logic          boot_mode;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rxv_cnt = 0;
  int we_long = 0;
  logic we_prev = 1'b0;
  wr_t exp_q[$];
  wr_t obs_q[$];

  uart_prog_loader #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .ADDR_W     (AW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .boot_mode(boot_mode),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) obs_q.push_back({mem_addr, mem_din});
    if (mem_we && we_prev) we_long <= we_long + 1;
    we_prev <= mem_we;
    if (done) done_cnt <= done_cnt + 1;
    if (dut.rx_valid) rxv_cnt <= rxv_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) tick();
    end
    uart_rx = stop_bit;
    repeat (CPB) tick();
    uart_rx = 1'b1;
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i], 1'b1);
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) tick();
    checks += 6;
    if (mem_addr !== '0) begin errors++; $display("FAIL rst_addr got %h exp 0", mem_addr); end
    if (mem_din !== 16'h0) begin errors++; $display("FAIL rst_din got %h exp 0", mem_din); end
    if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", mem_we); end
    if (boot_mode !== 1'b1) begin errors++; $display("FAIL rst_boot got %b exp 1", boot_mode); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
    rst = 1'b0;
    repeat (2000) tick();
    checks += 3;
    if (boot_mode !== 1'b1) begin errors++; $display("FAIL idle_boot got %b exp 1", boot_mode); end
    if (obs_q.size() != 0) begin errors++; $display("FAIL idle_we got %0d writes exp 0", obs_q.size()); end
    if (err !== 1'b0) begin errors++; $display("FAIL idle_err got %b exp 0", err); end
  endtask

  task automatic test_good_frame();
    int d0 = done_cnt;
    wr_t o, e;
    exp_q.push_back({11'd0, 16'h00A1});
    exp_q.push_back({11'd1, 16'h0078});
    send_bytes('{8'hA5, 8'h02, 8'h00, 8'hA1, 8'h00, 8'h78, 8'hD9});
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL good_nwr got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL good_wr got %h exp %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks += 4;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL good_done got %0d exp 1", done_cnt - d0); end
    if (boot_mode !== 1'b0) begin errors++; $display("FAIL good_boot got %b exp 0", boot_mode); end
    if (err !== 1'b0) begin errors++; $display("FAIL good_err got %b exp 0", err); end
    if (we_long != 0) begin errors++; $display("FAIL we_width got %0d exp 0", we_long); end
  endtask

  task automatic test_bad_csum();
    int d0 = done_cnt;
    wr_t o, e;
    exp_q.push_back({11'd0, 16'h00A1});
    exp_q.push_back({11'd1, 16'h0078});
    send_bytes('{8'hA5, 8'h02, 8'h00, 8'hA1, 8'h00, 8'h78, 8'h00});
    checks += 3;
    if (err !== 1'b1) begin errors++; $display("FAIL bad_err got %b exp 1", err); end
    if (boot_mode !== 1'b1) begin errors++; $display("FAIL bad_boot got %b exp 1", boot_mode); end
    if (done_cnt != d0) begin errors++; $display("FAIL bad_done got %0d exp 0", done_cnt - d0); end
    send_bytes('{8'hA5});
    checks += 2;
    if (err !== 1'b0) begin errors++; $display("FAIL resync_err got %b exp 0", err); end
    if (boot_mode !== 1'b1) begin errors++; $display("FAIL resync_boot got %b exp 1", boot_mode); end
    exp_q.push_back({11'd0, 16'h00A1});
    exp_q.push_back({11'd1, 16'h0078});
    send_bytes('{8'h02, 8'h00, 8'hA1, 8'h00, 8'h78, 8'hD9});
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bad_nwr got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL bad_wr got %h exp %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks += 3;
    if (boot_mode !== 1'b0) begin errors++; $display("FAIL reload_boot got %b exp 0", boot_mode); end
    if (err !== 1'b0) begin errors++; $display("FAIL reload_err got %b exp 0", err); end
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL reload_done got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_n_zero();
    int d0 = done_cnt;
    send_bytes('{8'h3C, 8'hFF, 8'hA5, 8'h00, 8'h00});
    checks += 4;
    if (obs_q.size() != 0) begin errors++; $display("FAIL n0_we got %0d exp 0", obs_q.size()); end
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL n0_done got %0d exp 1", done_cnt - d0); end
    if (boot_mode !== 1'b0) begin errors++; $display("FAIL n0_boot got %b exp 0", boot_mode); end
    if (err !== 1'b0) begin errors++; $display("FAIL n0_err got %b exp 0", err); end
    obs_q.delete();
  endtask

  task automatic test_timeout();
    send_bytes('{8'hA5, 8'h03, 8'h12});
    checks++;
    if (dut.state !== LO) begin errors++; $display("FAIL to_pre_state got %0d exp %0d", dut.state, LO); end
    repeat (TO + 10) tick();
    checks += 4;
    if (err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", err); end
    if (dut.state !== IDLE) begin errors++; $display("FAIL to_state got %0d exp 0", dut.state); end
    if (obs_q.size() != 0) begin errors++; $display("FAIL to_we got %0d exp 0", obs_q.size()); end
    if (boot_mode !== 1'b1) begin errors++; $display("FAIL to_boot got %b exp 1", boot_mode); end
    obs_q.delete();
  endtask

  task automatic test_frame_err();
    send_bytes('{8'hA5, 8'h01});
    checks += 2;
    if (err !== 1'b0) begin errors++; $display("FAIL fe_pre_err got %b exp 0", err); end
    if (dut.state !== HI) begin errors++; $display("FAIL fe_pre_state got %0d exp %0d", dut.state, HI); end
    send_byte(8'h55, 1'b0);
    repeat (4 * CPB) tick();
    checks += 4;
    if (err !== 1'b1) begin errors++; $display("FAIL fe_err got %b exp 1", err); end
    if (dut.state !== IDLE) begin errors++; $display("FAIL fe_state got %0d exp 0", dut.state); end
    if (obs_q.size() != 0) begin errors++; $display("FAIL fe_we got %0d exp 0", obs_q.size()); end
    if (boot_mode !== 1'b1) begin errors++; $display("FAIL fe_boot got %b exp 1", boot_mode); end
    obs_q.delete();
  endtask

  task automatic test_glitch();
    int r0, d0;
    send_bytes('{8'hA5, 8'h00});
    r0 = rxv_cnt;
    uart_rx = 1'b0;
    repeat (CPB / 2 - 3) tick();
    uart_rx = 1'b1;
    repeat (12 * CPB) tick();
    checks += 3;
    if (rxv_cnt != r0) begin errors++; $display("FAIL gl_byte got %0d exp 0", rxv_cnt - r0); end
    if (dut.state !== CSUM) begin errors++; $display("FAIL gl_state got %0d exp %0d", dut.state, CSUM); end
    if (err !== 1'b0) begin errors++; $display("FAIL gl_err got %b exp 0", err); end
    d0 = done_cnt;
    send_bytes('{8'h00});
    checks += 2;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL gl_done got %0d exp 1", done_cnt - d0); end
    if (boot_mode !== 1'b0) begin errors++; $display("FAIL gl_boot got %b exp 0", boot_mode); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b = 8'hA1;
    send_bytes('{8'hA5, 8'h02, 8'h00});
    uart_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 3; i++) begin
      uart_rx = b[i];
      repeat (CPB) tick();
    end
    rst = 1'b1;
    repeat (2) tick();
    checks += 7;
    if (mem_addr !== '0) begin errors++; $display("FAIL mid_addr got %h exp 0", mem_addr); end
    if (mem_din !== 16'h0) begin errors++; $display("FAIL mid_din got %h exp 0", mem_din); end
    if (mem_we !== 1'b0) begin errors++; $display("FAIL mid_we got %b exp 0", mem_we); end
    if (boot_mode !== 1'b1) begin errors++; $display("FAIL mid_boot got %b exp 1", boot_mode); end
    if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %b exp 0", done); end
    if (err !== 1'b0) begin errors++; $display("FAIL mid_err got %b exp 0", err); end
    if (dut.state !== IDLE) begin errors++; $display("FAIL mid_state got %0d exp 0", dut.state); end
    uart_rx = 1'b1;
    rst = 1'b0;
    repeat (12 * CPB) tick();
    checks += 3;
    if (obs_q.size() != 0) begin errors++; $display("FAIL mid_wr got %0d exp 0", obs_q.size()); end
    if (dut.state !== IDLE) begin errors++; $display("FAIL mid_idle got %0d exp 0", dut.state); end
    if (we_long != 0) begin errors++; $display("FAIL mid_width got %0d exp 0", we_long); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_n_zero();
    test_timeout();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
